// File: rtl/definitions_pkg.sv
// Shared image geometry, output-FIFO sizing and unloader types.
// Used by the line-buffer loader and the pixel unloader.
package definitions_pkg;

  localparam int IMAGE_WIDTH     = 512;
  localparam int IMAGE_HEIGHT    = 512;
  localparam int OUT_FIFO_DEPTH  = 2048;
  localparam int OUT_AFULL_LEVEL = 1536;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } unloader_state_t;

  typedef struct packed {
    logic [7:0] pixel;
    logic       sof;
    logic       eol;
    logic       eof;
  } out_beat_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a drop flag.
// A write into a full FIFO succeeds when a read frees a slot that cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign drop    = wr_en && !wr_ok;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_unloader.sv
// Buffers filtered pixels and re-emits them as a framed ready/valid stream.
// Build option BORDER_ZERO_EN zeroes the first and last column of each line.
module pixel_unloader
  import definitions_pkg::*;
#(
  parameter int LINE_WIDTH  = IMAGE_WIDTH,
  parameter int NUM_LINES   = IMAGE_HEIGHT - 2,
  parameter int FIFO_DEPTH  = OUT_FIFO_DEPTH,
  parameter int AFULL_LEVEL = OUT_AFULL_LEVEL
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic [7:0] pixel_in,
  input  logic       pixel_in_valid,
  output logic       almost_full,
  output logic [7:0] pixel_out,
  output logic       pixel_out_valid,
  input  logic       pixel_out_ready,
  output logic       sof,
  output logic       eol,
  output logic       eof,
  output logic       frame_done,
  output logic       overflow_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int RW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(NUM_LINES - 1);
  localparam logic [AW:0]   AF_LVL   = (AW+1)'(AFULL_LEVEL);

  logic [7:0]      wr_data;
  logic [7:0]      fifo_rd_data;
  logic            fifo_empty;
  logic            fifo_drop;
  logic [AW:0]     fifo_count;
  logic            rd_en;
  logic            accept;

  logic [CW-1:0]   out_col;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   nxt_col;
  logic [RW-1:0]   nxt_row;
  logic [CW-1:0]   ld_col;
  logic [RW-1:0]   ld_row;
  out_beat_t       ld_beat;
  out_beat_t       out_q;
  unloader_state_t state;

`ifdef BORDER_ZERO_EN
  logic [CW-1:0] wr_col;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_col <= '0;
    end else if (pixel_in_valid) begin
      wr_col <= (wr_col == COL_LAST) ? '0 : wr_col + CW'(1);
    end
  end

  assign wr_data = (wr_col == '0 || wr_col == COL_LAST) ? 8'h00 : pixel_in;
`else
  assign wr_data = pixel_in;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstN    (rstN),
    .wr_en   (pixel_in_valid),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .drop    (fifo_drop),
    .count   (fifo_count)
  );

  assign accept = pixel_out_valid && pixel_out_ready;
  assign rd_en  = (!pixel_out_valid || pixel_out_ready) && !fifo_empty;

  // Counters name the beat in the stage; a beat loaded while
  // the current one leaves takes the following position.
  always_comb begin
    nxt_col = out_col + CW'(1);
    nxt_row = out_row;
    if (out_col == COL_LAST) begin
      nxt_col = '0;
      nxt_row = (out_row == ROW_LAST) ? '0 : out_row + RW'(1);
    end
    ld_col        = accept ? nxt_col : out_col;
    ld_row        = accept ? nxt_row : out_row;
    ld_beat.pixel = fifo_rd_data;
    ld_beat.sof   = (ld_col == '0) && (ld_row == '0);
    ld_beat.eol   = (ld_col == COL_LAST);
    ld_beat.eof   = (ld_col == COL_LAST) && (ld_row == ROW_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      out_col         <= '0;
      out_row         <= '0;
      out_q           <= '0;
      pixel_out_valid <= 1'b0;
      almost_full     <= 1'b0;
      overflow_err    <= 1'b0;
    end else begin
      if (accept) begin
        out_col <= nxt_col;
        out_row <= nxt_row;
      end
      if (rd_en) begin
        out_q           <= ld_beat;
        pixel_out_valid <= 1'b1;
      end else if (accept) begin
        pixel_out_valid <= 1'b0;
      end
      almost_full  <= (fifo_count >= AF_LVL);
      overflow_err <= overflow_err | fifo_drop;
    end
  end

  assign pixel_out = out_q.pixel;
  assign sof       = out_q.sof;
  assign eol       = out_q.eol;
  assign eof       = out_q.eof;

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state      <= IDLE;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && out_q.eof;
      unique case (state)
        IDLE: begin
          if (accept && out_q.sof) begin
            state <= out_q.eof ? DONE : STREAM;
          end
        end
        STREAM: begin
          if (accept && out_q.eof) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (accept && out_q.sof) begin
            state <= out_q.eof ? DONE : STREAM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_unloader.sv
// Directed bench for pixel_unloader on a reduced 16x6 frame geometry.
// Each scenario task checks its own expected values inline.
module tb_pixel_unloader;

  localparam int LW    = 16;
  localparam int NL    = 6;
  localparam int DEPTH = 32;
  localparam int AFL   = 24;
  localparam int FRAME = LW * NL;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       pixel_in_valid = 1'b0;
  logic       almost_full;
  logic [7:0] pixel_out;
  logic       pixel_out_valid;
  logic       pixel_out_ready = 1'b0;
  logic       sof;
  logic       eol;
  logic       eof;
  logic       frame_done;
  logic       overflow_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pixel_unloader #(
    .LINE_WIDTH  (LW),
    .NUM_LINES   (NL),
    .FIFO_DEPTH  (DEPTH),
    .AFULL_LEVEL (AFL)
  ) dut (
    .clk             (clk),
    .rstN            (rstN),
    .pixel_in        (pixel_in),
    .pixel_in_valid  (pixel_in_valid),
    .almost_full     (almost_full),
    .pixel_out       (pixel_out),
    .pixel_out_valid (pixel_out_valid),
    .pixel_out_ready (pixel_out_ready),
    .sof             (sof),
    .eol             (eol),
    .eof             (eof),
    .frame_done      (frame_done),
    .overflow_err    (overflow_err)
  );

  // Expected stored value for the idx-th write since reset.
  function automatic logic [7:0] exp_px(int idx, logic [7:0] v);
`ifdef BORDER_ZERO_EN
    if ((idx % LW) == 0 || (idx % LW) == LW - 1) return 8'h00;
`endif
    return v;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    pixel_in_valid  = 1'b0;
    pixel_out_ready = 1'b0;
    rstN            = 1'b0;
    @(posedge clk);
    #1;
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    rstN            = 1'b0;
    pixel_in        = 8'h33;
    pixel_in_valid  = 1'b1;
    pixel_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({pixel_out_valid, sof, eol, eof, frame_done, almost_full,
         overflow_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000000",
               {pixel_out_valid, sof, eol, eof, frame_done,
                almost_full, overflow_err});
    end
    checks++;
    if (pixel_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_pixel got %h want 00", pixel_out);
    end
    @(posedge clk);
    #1;
    pixel_in_valid = 1'b0;
    rstN           = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pixel_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_nowrite got %b want 0", pixel_out_valid);
    end
  endtask

  task automatic test_single_latency();
    do_reset();
    pixel_out_ready = 1'b1;
    @(posedge clk);
    #1;
    pixel_in       = 8'hA5;
    pixel_in_valid = 1'b1;
    @(posedge clk);
    #1;
    pixel_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pixel_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_n1 valid got %b want 0", pixel_out_valid);
    end
    @(negedge clk);
    checks++;
    if ({pixel_out_valid, pixel_out, sof, eol, eof} !==
        {1'b1, exp_px(0, 8'hA5), 3'b100}) begin
      errors++;
      $display("FAIL single_n2 got v=%b px=%h s/l/f=%b%b%b want 1 %h 100",
               pixel_out_valid, pixel_out, sof, eol, eof,
               exp_px(0, 8'hA5));
    end
    @(negedge clk);
    checks++;
    if (pixel_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_dup valid got %b want 0", pixel_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    int beats;
    int cyc;
    int tail;
    int fd_seen;
    int fd_bad;
    int k;
    logic fd_exp;
    logic [10:0] exp;
    do_reset();
    pixel_out_ready = 1'b1;
    beats   = 0;
    cyc     = 0;
    tail    = 0;
    fd_seen = 0;
    fd_bad  = 0;
    fd_exp  = 1'b0;
    fork
      begin
        for (int i = 0; i < 2 * FRAME; i++) begin
          @(posedge clk);
          #1;
          pixel_in       = 8'(i);
          pixel_in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        pixel_in_valid = 1'b0;
      end
      begin
        while (cyc < 1000 && tail < 3) begin
          @(negedge clk);
          cyc++;
          if (frame_done !== fd_exp) fd_bad++;
          if (frame_done === 1'b1) fd_seen++;
          fd_exp = 1'b0;
          if (pixel_out_valid && pixel_out_ready) begin
            k   = beats % FRAME;
            exp = {exp_px(beats, 8'(beats)), k == 0,
                   (k % LW) == LW - 1, k == FRAME - 1};
            checks++;
            if ({pixel_out, sof, eol, eof} !== exp) begin
              errors++;
              $display("FAIL frame_beat%0d got %h want %h", beats,
                       {pixel_out, sof, eol, eof}, exp);
            end
            fd_exp = (k == FRAME - 1);
            beats++;
          end
          if (beats >= 2 * FRAME) tail++;
        end
      end
    join
    checks++;
    if (beats !== 2 * FRAME) begin
      errors++;
      $display("FAIL frame_count got %0d want %0d", beats, 2 * FRAME);
    end
    checks++;
    if (fd_bad !== 0) begin
      errors++;
      $display("FAIL frame_done_timing got %0d bad cycles want 0", fd_bad);
    end
    checks++;
    if (fd_seen !== 2) begin
      errors++;
      $display("FAIL frame_done_pulses got %0d want 2", fd_seen);
    end
  endtask

  task automatic test_stall_toggle();
    int beats;
    int cyc;
    logic stalled;
    logic [11:0] snap;
    logic [10:0] exp;
    do_reset();
    for (int i = 0; i < LW; i++) begin
      @(posedge clk);
      #1;
      pixel_in       = 8'h40 + 8'(i);
      pixel_in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    pixel_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    beats   = 0;
    cyc     = 0;
    stalled = 1'b0;
    snap    = '0;
    while (beats < LW && cyc < 200) begin
      @(posedge clk);
      #1;
      pixel_out_ready = ~pixel_out_ready;
      @(negedge clk);
      cyc++;
      if (stalled) begin
        checks++;
        if ({pixel_out_valid, pixel_out, sof, eol, eof} !== snap) begin
          errors++;
          $display("FAIL stall_hold got %h want %h",
                   {pixel_out_valid, pixel_out, sof, eol, eof}, snap);
        end
      end
      stalled = pixel_out_valid && !pixel_out_ready;
      snap    = {pixel_out_valid, pixel_out, sof, eol, eof};
      if (pixel_out_valid && pixel_out_ready) begin
        exp = {exp_px(beats, 8'h40 + 8'(beats)), beats == 0,
               beats == LW - 1, 1'b0};
        checks++;
        if ({pixel_out, sof, eol, eof} !== exp) begin
          errors++;
          $display("FAIL stall_beat%0d got %h want %h", beats,
                   {pixel_out, sof, eol, eof}, exp);
        end
        beats++;
      end
    end
    @(posedge clk);
    #1;
    pixel_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (beats !== LW) begin
      errors++;
      $display("FAIL stall_count got %0d want %0d", beats, LW);
    end
    checks++;
    if (pixel_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_extra valid got %b want 0", pixel_out_valid);
    end
  endtask

  task automatic test_overflow();
    int beats;
    int cyc;
    int idle;
    do_reset();
    @(posedge clk);
    #1;
    pixel_in       = 8'h00;
    pixel_in_valid = 1'b1;
    // Stage holds one entry, so DEPTH+1 writes fit and the next drops.
    for (int k = 1; k <= DEPTH + 2; k++) begin
      @(posedge clk);
      #1;
      if (k < DEPTH + 2) pixel_in = 8'(k);
      else pixel_in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (almost_full !== (k >= AFL + 2)) begin
        errors++;
        $display("FAIL afull_w%0d got %b want %b", k, almost_full,
                 (k >= AFL + 2));
      end
      checks++;
      if (overflow_err !== (k >= DEPTH + 2)) begin
        errors++;
        $display("FAIL ovf_w%0d got %b want %b", k, overflow_err,
                 (k >= DEPTH + 2));
      end
    end
    @(posedge clk);
    #1;
    pixel_out_ready = 1'b1;
    beats = 0;
    cyc   = 0;
    idle  = 0;
    while (cyc < 200 && idle < 4) begin
      @(negedge clk);
      cyc++;
      if (pixel_out_valid && pixel_out_ready) begin
        idle = 0;
        if (beats < DEPTH + 1) begin
          checks++;
          if (pixel_out !== exp_px(beats, 8'(beats))) begin
            errors++;
            $display("FAIL ovf_beat%0d got %h want %h", beats, pixel_out,
                     exp_px(beats, 8'(beats)));
          end
        end
        beats++;
      end else begin
        idle++;
      end
    end
    checks++;
    if (beats !== DEPTH + 1) begin
      errors++;
      $display("FAIL ovf_count got %0d want %0d", beats, DEPTH + 1);
    end
    checks++;
    if ({overflow_err, almost_full} !== 2'b10) begin
      errors++;
      $display("FAIL ovf_sticky got err/af=%b%b want 10", overflow_err,
               almost_full);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    logic found;
    do_reset();
    pixel_out_ready = 1'b1;
    for (int i = 0; i < 3 * LW + 5; i++) begin
      @(posedge clk);
      #1;
      pixel_in       = 8'h80 + 8'(i);
      pixel_in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    rstN     = 1'b0;
    pixel_in = 8'hEE;
    @(posedge clk);
    #1;
    rstN           = 1'b1;
    pixel_in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({pixel_out_valid, pixel_out, sof, eol, eof, frame_done,
         almost_full, overflow_err} !== 15'b0) begin
      errors++;
      $display("FAIL midrst_out got %h want 0000",
               {pixel_out_valid, pixel_out, sof, eol, eof, frame_done,
                almost_full, overflow_err});
    end
    @(posedge clk);
    #1;
    pixel_in       = 8'h77;
    pixel_in_valid = 1'b1;
    @(posedge clk);
    #1;
    pixel_in_valid = 1'b0;
    cyc   = 0;
    found = 1'b0;
    while (!found && cyc < 10) begin
      @(negedge clk);
      cyc++;
      found = pixel_out_valid;
    end
    checks++;
    if ({found, pixel_out, sof, eol, eof} !==
        {1'b1, exp_px(0, 8'h77), 3'b100}) begin
      errors++;
      $display("FAIL midrst_first got v=%b px=%h s/l/f=%b%b%b want 1 %h 100",
               found, pixel_out, sof, eol, eof, exp_px(0, 8'h77));
    end
  endtask

  task automatic test_border();
    int beats;
    int cyc;
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < LW; i++) begin
      @(posedge clk);
      #1;
      pixel_in       = 8'hFF;
      pixel_in_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    pixel_in_valid  = 1'b0;
    pixel_out_ready = 1'b1;
    beats = 0;
    cyc   = 0;
    while (beats < LW && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (pixel_out_valid && pixel_out_ready) begin
`ifdef BORDER_ZERO_EN
        want = (beats == 0 || beats == LW - 1) ? 8'h00 : 8'hFF;
`else
        want = 8'hFF;
`endif
        checks++;
        if (pixel_out !== want) begin
          errors++;
          $display("FAIL border_col%0d got %h want %h", beats, pixel_out,
                   want);
        end
        beats++;
      end
    end
    checks++;
    if (beats !== LW) begin
      errors++;
      $display("FAIL border_count got %0d want %0d", beats, LW);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_back_to_back();
    test_stall_toggle();
    test_overflow();
    test_mid_reset();
    test_border();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
